// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, baud divisor calculation and
// the line-terminator byte values carried through the sample FIFO.
package uart_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_LAT   = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    // Integer-truncated clk cycles per bit; legal results are 2..65535.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter: counts 0..DIV-1, wraps, and restarts from
// zero whenever the controlling FSM changes state.
module uart_baud_cnt #(
    parameter int unsigned DIV = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_tick
);

    logic [15:0] count;

    assign bit_tick = (count == 16'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a normal-mode byte FIFO and serialises each byte as an 8N1 (or 8N2)
// UART frame, LSB first, on a registered idle-high tx line.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_q,
    output logic       fifo_rdreq,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       bit_tick;
    logic       state_change;
    logic       last_stop;

    assign state_change = (state_next != state);
    // bit_cnt doubles as the stop-bit counter so STOP_BITS=2 needs no extra state.
    assign last_stop    = (bit_cnt == 3'(STOP_BITS - 1));

    uart_baud_cnt #(
        .DIV (BAUD_DIV)
    ) u_baud_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (state_change),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (enable && !fifo_empty) state_next = S_REQ;
            S_REQ:   state_next = S_LAT;
            S_LAT:   state_next = S_START;
            S_START: if (bit_tick) state_next = S_DATA;
            S_DATA:  if (bit_tick && bit_cnt == 3'd7) state_next = S_STOP;
            S_STOP:  if (bit_tick && last_stop) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            state <= state_next;
            if (state_change) begin
                bit_cnt <= '0;
            end else if (bit_tick && (state == S_DATA || state == S_STOP)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            case (state)
                S_START: tx <= 1'b0;
                S_DATA:  tx <= shift_reg[0];
                default: tx <= 1'b1;
            endcase
        end
    end

    // FIFO q is only meaningful the cycle after rdreq, i.e. in S_LAT.
    always_ff @(posedge clk) begin
        if (state == S_LAT) begin
            shift_reg <= fifo_q;
        end else if (state == S_DATA && bit_tick) begin
            shift_reg <= shift_reg >> 1;
        end
    end

    assign fifo_rdreq = (state == S_REQ);
    assign busy       = (state != S_IDLE);
    assign tx_done    = (state == S_STOP) && bit_tick && last_stop;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: normal-mode FIFO models feed two DUT
// configurations; tx waveforms are compared against a frame-level timing model.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    // ---------------- DUT A: BAUD_DIV=10, 1 stop bit ----------------
    logic       enable_a;
    logic       empty_a;
    logic [7:0] q_a = 8'h00;
    logic       rdreq_a, tx_a, busy_a, done_a;
    logic [7:0] mem_a [0:63];
    int         wr_a = 0;
    int         rd_a = 0;
    logic       under_a = 1'b0;

    assign empty_a = (wr_a == rd_a);

    always @(posedge clk) begin
        if (rdreq_a) begin
            if (wr_a == rd_a) under_a <= 1'b1;
            else begin
                q_a  <= mem_a[rd_a[5:0]];
                rd_a <= rd_a + 1;
            end
        end
    end

    fifo_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(1)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable_a),
        .fifo_empty (empty_a),
        .fifo_q     (q_a),
        .fifo_rdreq (rdreq_a),
        .tx         (tx_a),
        .busy       (busy_a),
        .tx_done    (done_a)
    );

    // ---------------- DUT B: BAUD_DIV=434, 2 stop bits ----------------
    logic       enable_b;
    logic       empty_b;
    logic [7:0] q_b = 8'h00;
    logic       rdreq_b, tx_b, busy_b, done_b;
    logic [7:0] mem_b [0:15];
    int         wr_b = 0;
    int         rd_b = 0;
    logic       under_b = 1'b0;

    assign empty_b = (wr_b == rd_b);

    always @(posedge clk) begin
        if (rdreq_b) begin
            if (wr_b == rd_b) under_b <= 1'b1;
            else begin
                q_b  <= mem_b[rd_b[3:0]];
                rd_b <= rd_b + 1;
            end
        end
    end

    fifo_uart_tx #(.CLK_FREQ(43400), .BAUD(100), .STOP_BITS(2)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable_b),
        .fifo_empty (empty_b),
        .fifo_q     (q_b),
        .fifo_rdreq (rdreq_b),
        .tx         (tx_b),
        .busy       (busy_b),
        .tx_done    (done_b)
    );

    // ---------------- capture buffers and reference model ----------------
    logic txs [0:399];
    logic rqs [0:399];
    logic bss [0:399];
    logic dns [0:399];
    logic [7:0] exp_bytes [0:3];
    int         exp_n;

    // Index 0 is the rdreq cycle of the first frame. The start bit appears on tx
    // three cycles later; each frame is 100 clk and frames are separated by 3 clk.
    function automatic logic exp_tx(input int i);
        int j, off, k;
        if (i < 3) return 1'b1;
        j   = (i - 3) / 103;
        off = (i - 3) % 103;
        if (j >= exp_n || off >= 100) return 1'b1;
        k = off / 10;
        if (k == 0) return 1'b0;
        if (k <= 8) return exp_bytes[j][k-1];
        return 1'b1;
    endfunction

    task automatic push_a(input logic [7:0] b);
        mem_a[wr_a[5:0]] = b;
        wr_a = wr_a + 1;
    endtask

    task automatic capture_a(input int n);
        for (int i = 0; i < n; i++) begin
            txs[i] = tx_a; rqs[i] = rdreq_a; bss[i] = busy_a; dns[i] = done_a;
            @(negedge clk);
        end
    endtask

    task automatic wait_rdreq_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rdreq_a) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    function automatic int wave_mismatch(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (txs[i] !== exp_tx(i)) m++;
        return m;
    endfunction

    function automatic int count_ones_rq(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (rqs[i] === 1'b1) c++;
        return c;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset;
        int viol = 0;
        reset_n = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_a, rdreq_a, busy_a, done_a} !== 4'b1000) begin
            errors++; $display("FAIL reset_values got tx/rdreq/busy/done=%b want 1000", {tx_a, rdreq_a, busy_a, done_a});
        end
        reset_n = 1'b1; enable_a = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || rdreq_a !== 1'b0 || busy_a !== 1'b0) viol++;
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL idle_empty_fifo got %0d bad cycles want 0", viol);
        end
    endtask

    task automatic test_single_byte;
        bit ok;
        int m, dc;
        exp_bytes[0] = 8'hA5; exp_n = 1;
        push_a(8'hA5);
        wait_rdreq_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_rdreq_timeout got none want rdreq"); return; end
        capture_a(130);
        m = wave_mismatch(130);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL single_wave got %0d mismatching cycles want 0", m); end
        checks++;
        if (count_ones_rq(130) !== 1 || rqs[1] !== 1'b0) begin
            errors++; $display("FAIL single_rdreq_pulse got %0d pulses want 1", count_ones_rq(130));
        end
        dc = 0;
        for (int i = 0; i < 130; i++) if (dns[i] === 1'b1) dc++;
        checks++;
        if (dc !== 1 || dns[101] !== 1'b1) begin
            errors++; $display("FAIL single_tx_done got count=%0d at101=%b want 1 and 1", dc, dns[101]);
        end
        checks++;
        if ({bss[0], bss[101], bss[102]} !== 3'b110) begin
            errors++; $display("FAIL single_busy got %b want 110", {bss[0], bss[101], bss[102]});
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int m, fall;
        exp_bytes[0] = 8'h30; exp_bytes[1] = 8'h0D; exp_bytes[2] = 8'h0A; exp_n = 3;
        push_a(8'h30); push_a(8'h0D); push_a(8'h0A);
        wait_rdreq_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_rdreq_timeout got none want rdreq"); return; end
        capture_a(340);
        m = wave_mismatch(340);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL b2b_wave got %0d mismatching cycles want 0", m); end
        checks++;
        if (count_ones_rq(340) !== 3 || rqs[103] !== 1'b1 || rqs[206] !== 1'b1) begin
            errors++; $display("FAIL b2b_rdreq got %0d pulses want 3 at 0,103,206", count_ones_rq(340));
        end
        fall = -1;
        for (int i = 93; i < 200; i++) if (txs[i] === 1'b0) begin fall = i; break; end
        checks++;
        if (fall - 103 !== 3) begin errors++; $display("FAIL b2b_gap got %0d clk want 3", fall - 103); end
    endtask

    task automatic test_enable;
        bit ok;
        int rq = 0;
        int busy_seen = 0;
        enable_a = 1'b0;
        push_a(8'h55); push_a(8'h66);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdreq_a === 1'b1) rq++;
            if (busy_a === 1'b1) busy_seen++;
        end
        checks++;
        if (rq !== 0 || busy_seen !== 0) begin
            errors++; $display("FAIL enable_low_read got rdreq=%0d busy=%0d want 0 0", rq, busy_seen);
        end
        exp_bytes[0] = 8'h55; exp_n = 1;
        enable_a = 1'b1;
        wait_rdreq_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL enable_rdreq_timeout got none want rdreq"); return; end
        for (int i = 0; i < 250; i++) begin
            txs[i] = tx_a; rqs[i] = rdreq_a;
            if (i == 55) enable_a = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (wave_mismatch(250) !== 0) begin
            errors++; $display("FAIL enable_drop_wave got %0d mismatching cycles want 0", wave_mismatch(250));
        end
        checks++;
        if (count_ones_rq(250) !== 1 || wr_a - rd_a !== 1) begin
            errors++; $display("FAIL enable_drop_reads got %0d pulses, %0d left want 1, 1", count_ones_rq(250), wr_a - rd_a);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int popped;
        enable_a = 1'b1;
        wait_rdreq_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_rdreq_timeout got none want rdreq"); return; end
        repeat (47) @(negedge clk);
        checks++;
        if (tx_a !== 1'b0) begin errors++; $display("FAIL midreset_pre_tx got %b want 0 (bit3 of 0x66)", tx_a); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx_a, busy_a, rdreq_a} !== 3'b100) begin
            errors++; $display("FAIL midreset_async got tx/busy/rdreq=%b want 100", {tx_a, busy_a, rdreq_a});
        end
        popped = rd_a;
        push_a(8'h3C);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        exp_bytes[0] = 8'h3C; exp_n = 1;
        wait_rdreq_a(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_resume_timeout got none want rdreq"); return; end
        capture_a(130);
        checks++;
        if (wave_mismatch(130) !== 0) begin
            errors++; $display("FAIL midreset_next_wave got %0d mismatching cycles want 0", wave_mismatch(130));
        end
        checks++;
        if (rd_a - popped !== 1 || wr_a !== rd_a) begin
            errors++; $display("FAIL midreset_reads got %0d extra reads want 1", rd_a - popped);
        end
    endtask

    task automatic test_two_stop_bits;
        bit ok = 1'b0;
        int fall = -1, low_len = 0, done_idx = -1, done_cnt = 0, idle_idx = -1, late_low = 0;
        mem_b[wr_b[3:0]] = 8'hFF; wr_b = wr_b + 1;
        enable_b = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (rdreq_b) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stop2_rdreq_timeout got none want rdreq"); return; end
        for (int i = 0; i < 4900; i++) begin
            if (tx_b === 1'b0) begin
                if (fall < 0) fall = i;
                if (i < fall + 434) low_len++; else late_low++;
            end
            if (done_b === 1'b1) begin done_cnt++; done_idx = i; end
            if (busy_b === 1'b0 && idle_idx < 0) idle_idx = i;
            @(negedge clk);
        end
        enable_b = 1'b0;
        checks++;
        if (fall !== 3 || low_len !== 434 || late_low !== 0) begin
            errors++; $display("FAIL stop2_start_bit got fall=%0d low=%0d late=%0d want 3 434 0", fall, low_len, late_low);
        end
        checks++;
        if (done_cnt !== 1 || done_idx - fall + 2 !== 4774) begin
            errors++; $display("FAIL stop2_frame_len got %0d clk (dones=%0d) want 4774", done_idx - fall + 2, done_cnt);
        end
        checks++;
        if (done_idx - (fall - 1 + 9 * 434) + 1 !== 868 || idle_idx !== done_idx + 1) begin
            errors++; $display("FAIL stop2_stop_len got %0d clk idle_at=%0d want 868 and %0d", done_idx - (fall - 1 + 9 * 434) + 1, idle_idx, done_idx + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_enable();
        test_reset_mid_frame();
        test_two_stop_bits();
        checks++;
        if (under_a !== 1'b0 || under_b !== 1'b0) begin
            errors++; $display("FAIL underflow got a=%b b=%b want 0 0", under_a, under_b);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
